// File: rtl/alu_pkg.sv
// Shared ALU op codes, MIPS opcode/funct values and issue-FSM states for the
// ALU issue controller and the instruction decoder.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct to ALU op decoder; also flags slt and
// encodings that map to no legal ALU operation.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       is_slt,
  output logic       illegal
);

  always_comb begin
    alu_op  = OP_ADD;
    is_slt  = 1'b0;
    illegal = 1'b0;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FN_ADD:  alu_op = OP_ADD;
        FN_SUB:  alu_op = OP_SUB;
        FN_AND:  alu_op = OP_AND;
        FN_OR:   alu_op = OP_OR;
        FN_XOR:  alu_op = OP_XOR;
        FN_MULT: alu_op = OP_MUL;
        // slt is a subtract whose sign bit becomes the result
        FN_SLT: begin
          alu_op = OP_SUB;
          is_slt = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OPC_ADDI, OPC_LW, OPC_SW: alu_op = OP_ADD;
        OPC_BEQ:                  alu_op = OP_SUB;
        OPC_ANDI:                 alu_op = OP_AND;
        OPC_ORI:                  alu_op = OP_OR;
        default:                  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared combinational ALU: decode, drive, capture, respond.
// Optional macro ALU_MULT_STALL_EN holds EXEC for MULT_CYCLES extra cycles on multiply.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int n           = 31,
  parameter int MULT_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [n:0]   a,
  input  logic [n:0]   b,
  output logic [n:0]   alu_in0,
  output logic [n:0]   alu_in1,
  output logic [2:0]   alu_op,
  input  logic [n:0]   alu_out,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [n:0]   result,
  output logic         zero,
  output logic         illegal
);

  state_t       state_q, state_d;
  logic [n:0]   in0_q, in0_d, in1_q, in1_d;
  logic [n:0]   result_q, result_d;
  logic [2:0]   op_q, op_d;
  logic         slt_q, slt_d, ill_q, ill_d, zero_q, zero_d;
  logic [2:0]   dec_op;
  logic         dec_slt, dec_ill;
  logic         capture;

`ifdef ALU_MULT_STALL_EN
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
`else
  // Stall depth only matters when the multiply stall is built in.
  logic unused_mult_cfg;
  assign unused_mult_cfg = ^4'(MULT_CYCLES);
`endif

  function automatic logic [n:0] capture_value(input logic [n:0] alu_res,
                                               input logic       is_slt,
                                               input logic       is_ill);
    if (is_ill) return '0;
    if (is_slt) return {{n{1'b0}}, alu_res[n]};
    return alu_res;
  endfunction

  alu_op_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_op),
    .is_slt  (dec_slt),
    .illegal (dec_ill)
  );

  always_comb begin
    state_d  = state_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    op_d     = op_q;
    slt_d    = slt_q;
    ill_d    = ill_q;
    result_d = result_q;
    zero_d   = zero_q;
    capture  = 1'b0;
`ifdef ALU_MULT_STALL_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          in0_d   = a;
          in1_d   = b;
          op_d    = dec_op;
          slt_d   = dec_slt;
          ill_d   = dec_ill;
          state_d = ST_EXEC;
`ifdef ALU_MULT_STALL_EN
          cnt_d   = (dec_op == OP_MUL) ? MULT_LOAD : 4'd0;
`endif
        end
      end
      ST_EXEC: begin
`ifdef ALU_MULT_STALL_EN
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else capture = 1'b1;
`else
        capture = 1'b1;
`endif
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // ALU output has settled over the whole EXEC cycle; latch it here
    if (capture) begin
      result_d = capture_value(alu_out, slt_q, ill_q);
      zero_d   = (result_d == '0);
      state_d  = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      in0_q    <= '0;
      in1_q    <= '0;
      op_q     <= OP_ADD;
      slt_q    <= 1'b0;
      ill_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_MULT_STALL_EN
      cnt_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      op_q     <= op_d;
      slt_q    <= slt_d;
      ill_q    <= ill_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_MULT_STALL_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign alu_in0    = in0_q;
  assign alu_in1    = in1_q;
  assign alu_op     = op_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: transaction-level model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_alu_issue_ctrl;
  localparam int N  = 31;
  localparam int MC = 3;
`ifdef ALU_MULT_STALL_EN
  localparam bit STALL   = 1'b1;
  localparam int MUL_LAT = 2 + MC;
`else
  localparam bit STALL   = 1'b0;
  localparam int MUL_LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         resp_ready = 1'b0;
  logic [5:0]   opcode = '0;
  logic [5:0]   funct = '0;
  logic [N:0]   a = '0;
  logic [N:0]   b = '0;
  logic [N:0]   alu_out;
  logic         req_ready, resp_valid, zero, illegal;
  logic [N:0]   alu_in0, alu_in1, result;
  logic [2:0]   alu_op;

  alu_issue_ctrl #(.n(N), .MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct(funct), .a(a), .b(b),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared combinational ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_out = alu_in0 + alu_in1;
      3'b001:  alu_out = alu_in0 - alu_in1;
      3'b100:  alu_out = alu_in0 & alu_in1;
      3'b101:  alu_out = alu_in0 | alu_in1;
      3'b110:  alu_out = alu_in0 ^ alu_in1;
      3'b111:  alu_out = alu_in0 * alu_in1;
      default: alu_out = '0;
    endcase
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Instruction table: {illegal, alu_op}
  function automatic logic [3:0] m_decode(input logic [5:0] opc, input logic [5:0] fn);
    if (opc == 6'b000000) begin
      case (fn)
        6'b100000: return 4'b0_000;
        6'b100010: return 4'b0_001;
        6'b100100: return 4'b0_100;
        6'b100101: return 4'b0_101;
        6'b100110: return 4'b0_110;
        6'b011000: return 4'b0_111;
        6'b101010: return 4'b0_001;
        default:   return 4'b1_000;
      endcase
    end
    case (opc)
      6'b001000, 6'b100011, 6'b101011: return 4'b0_000;
      6'b000100: return 4'b0_001;
      6'b001100: return 4'b0_100;
      6'b001101: return 4'b0_101;
      default:   return 4'b1_000;
    endcase
  endfunction

  // Instruction semantics straight from the instruction, not via the op code
  function automatic logic [N:0] m_result(input logic [5:0] opc, input logic [5:0] fn,
                                          input logic [N:0] x, input logic [N:0] y);
    logic [N:0] d;
    d = x - y;
    if (opc == 6'b000000) begin
      case (fn)
        6'b100000: return x + y;
        6'b100010: return x - y;
        6'b100100: return x & y;
        6'b100101: return x | y;
        6'b100110: return x ^ y;
        6'b011000: return x * y;
        6'b101010: return {{N{1'b0}}, d[N]};
        default:   return '0;
      endcase
    end
    case (opc)
      6'b001000, 6'b100011, 6'b101011: return x + y;
      6'b000100: return x - y;
      6'b001100: return x & y;
      6'b001101: return x | y;
      default:   return '0;
    endcase
  endfunction

  // Transaction model: outstanding flag plus age in cycles since accept
  bit         live = 1'b0;
  bit         m_out = 1'b0;
  int         m_age = 0;
  int         m_lat = 2;
  logic [5:0] m_opc = '0, m_fn = '0;
  logic [N:0] m_in0 = '0, m_in1 = '0, m_res = '0;
  logic [2:0] m_op = '0;
  logic       m_zero = 1'b0, m_ill = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      live = 1'b1; m_out = 1'b0; m_age = 0;
      m_in0 = '0; m_in1 = '0; m_op = '0; m_res = '0; m_zero = 1'b0; m_ill = 1'b0;
    end else if (live) begin
      if (m_out) begin
        if (m_age >= m_lat) begin
          if (resp_ready) m_out = 1'b0;
        end else begin
          m_age++;
          if (m_age == m_lat) begin
            m_res  = m_result(m_opc, m_fn, m_in0, m_in1);
            m_zero = (m_res == '0);
          end
        end
      end else if (req_valid) begin
        m_out = 1'b1; m_age = 1;
        m_opc = opcode; m_fn = funct; m_in0 = a; m_in1 = b;
        {m_ill, m_op} = m_decode(opcode, funct);
        m_lat = (STALL && m_op == 3'b111) ? 2 + MC : 2;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("cyc req_ready", req_ready, !m_out);
      chk("cyc resp_valid", resp_valid, m_out && (m_age >= m_lat));
      chk("cyc alu_in0", alu_in0, m_in0);
      chk("cyc alu_in1", alu_in1, m_in1);
      chk("cyc alu_op", alu_op, m_op);
      chk("cyc result", result, m_res);
      chk("cyc zero", zero, m_zero);
      chk("cyc illegal", illegal, m_ill);
    end
  end

  // One request/response; while in flight the requester keeps req_valid up with junk
  task automatic run_req(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [N:0] av, input logic [N:0] bv, input int hold,
                         input logic [N:0] exp_res, input logic exp_z, input logic exp_ill,
                         input logic [2:0] exp_op, input int exp_lat);
    int w, lat;
    opcode = opc; funct = fn; a = av; b = bv; req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      chk({nm, " accept"}, req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    opcode = 6'b111111; funct = 6'b111111; a = ~av; b = ~bv;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 40);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " result"}, result, exp_res);
    chk({nm, " zero"}, zero, exp_z);
    chk({nm, " illegal"}, illegal, exp_ill);
    chk({nm, " alu_op"}, alu_op, exp_op);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold result"}, result, exp_res);
      chk({nm, " hold req_ready"}, req_ready, 1'b0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst req_ready", req_ready, 1'b1);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst result", result, '0);
    chk("rst alu_op", alu_op, 3'b000);
    chk("rst illegal", illegal, 1'b0);
    @(posedge clk);
    #1;
    run_req("add",      6'b000000, 6'b100000, 32'd5,        32'd7,        0, 32'd12,       1'b0, 1'b0, 3'b000, 2);
    run_req("beq",      6'b000100, 6'b000000, 32'd9,        32'd9,        4, 32'd0,        1'b1, 1'b0, 3'b001, 2);
    run_req("slt_neg",  6'b000000, 6'b101010, 32'hFFFFFFFD, 32'd2,        0, 32'd1,        1'b0, 1'b0, 3'b001, 2);
    run_req("slt_pos",  6'b000000, 6'b101010, 32'd4,        32'd2,        0, 32'd0,        1'b1, 1'b0, 3'b001, 2);
    run_req("illegal",  6'b111111, 6'b000000, 32'd3,        32'd4,        0, 32'd0,        1'b1, 1'b1, 3'b000, 2);
    run_req("addi",     6'b001000, 6'b000000, 32'd100,      32'hFFFFFFFF, 0, 32'd99,       1'b0, 1'b0, 3'b000, 2);
    run_req("rtype_bad",6'b000000, 6'b000000, 32'd8,        32'd1,        0, 32'd0,        1'b1, 1'b1, 3'b000, 2);
    run_req("xor",      6'b000000, 6'b100110, 32'h0000F0F0, 32'h00000FF0, 0, 32'h0000FF00, 1'b0, 1'b0, 3'b110, 2);
    run_req("ori",      6'b001101, 6'b000000, 32'h10,       32'h01,       1, 32'h11,       1'b0, 1'b0, 3'b101, 2);
    run_req("andi",     6'b001100, 6'b000000, 32'hF0,       32'h0F,       0, 32'd0,        1'b1, 1'b0, 3'b100, 2);
    run_req("mult",     6'b000000, 6'b011000, 32'd6,        32'd7,        0, 32'd42,       1'b0, 1'b0, 3'b111, MUL_LAT);

    // Reset while the operation sits in EXEC
    opcode = 6'b000000; funct = 6'b100000; a = 32'd20; b = 32'd22; req_valid = 1'b1;
    @(negedge clk);
    chk("abort accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort resp_valid", resp_valid, 1'b0);
    chk("abort req_ready", req_ready, 1'b1);
    chk("abort alu_in0", alu_in0, '0);
    chk("abort result", result, '0);
    chk("abort zero", zero, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("abort no resp", resp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    run_req("post_rst", 6'b000000, 6'b100010, 32'd50,       32'd8,        0, 32'd42,       1'b0, 1'b0, 3'b001, 2);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
